// File: rtl/operand_forward_ctrl.sv
// ID/EX operand register with MEM/WB result forwarding, load-use stall
// generation and protocol-violation detection for the EX stage.
module operand_forward_ctrl #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs_a,
  input  logic [AW-1:0]    id_rs_b,
  input  logic             id_rd_a,
  input  logic             id_rd_b,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_wr_en,
  input  logic             id_is_load,
  input  logic [DW-1:0]    id_opa,
  input  logic [DW-1:0]    id_opb,
  input  logic [DW-1:0]    mem_frwd_data,
  input  logic [DW-1:0]    wb_data,
  output logic             stall_id,
  output logic             ex_valid,
  output logic [AW-1:0]    ex_rd,
  output logic             ex_wr_en,
  output logic             ex_is_load,
  output logic [DW-1:0]    ex_opa,
  output logic [DW-1:0]    ex_opb,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic             hazard_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    SEL_RF  = 2'b00,
    SEL_MEM = 2'b01,
    SEL_WB  = 2'b10
  } fwd_sel_e;

  logic             r_ex_valid;
  logic [AW-1:0]    r_ex_rd;
  logic             r_ex_wr_en;
  logic             r_ex_is_load;
  logic [AW-1:0]    r_ex_rs_a;
  logic [AW-1:0]    r_ex_rs_b;
  logic             r_ex_rd_a;
  logic             r_ex_rd_b;
  logic [DW-1:0]    r_ex_opa;
  logic [DW-1:0]    r_ex_opb;
  logic             r_mem_valid;
  logic [AW-1:0]    r_mem_rd;
  logic             r_mem_wr_en;
  logic             r_mem_is_load;
  logic             r_wb_valid;
  logic [AW-1:0]    r_wb_rd;
  logic             r_wb_wr_en;
  logic             r_wb_is_load;
  logic             r_hazard_err;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_stall;
  logic             w_bubble;
  logic             w_haz;
  logic [DW-1:0]    w_cap_a;
  logic [DW-1:0]    w_cap_b;
  fwd_sel_e         w_sel_a;
  fwd_sel_e         w_sel_b;
  logic [DW-1:0]    w_opa;
  logic [DW-1:0]    w_opb;

  assign w_stall = id_valid & ~flush & r_ex_valid & r_ex_wr_en & r_ex_is_load &
                   ((id_rd_a & (id_rs_a == r_ex_rd)) | (id_rd_b & (id_rs_b == r_ex_rd)));
  assign w_bubble = flush | w_stall;

  // Regfile returns the pre-write value when WB writes the register being read.
  assign w_cap_a = (r_wb_valid & r_wb_wr_en & id_rd_a & (id_rs_a == r_wb_rd)) ? wb_data : id_opa;
  assign w_cap_b = (r_wb_valid & r_wb_wr_en & id_rd_b & (id_rs_b == r_wb_rd)) ? wb_data : id_opb;

  assign w_haz = r_ex_valid & r_mem_valid & r_mem_wr_en & r_mem_is_load &
                 ((r_ex_rd_a & (r_mem_rd == r_ex_rs_a)) | (r_ex_rd_b & (r_mem_rd == r_ex_rs_b)));

  function automatic fwd_sel_e f_sel(input logic [AW-1:0] rs, input logic rdx);
    f_sel = SEL_RF;
    if (r_ex_valid && rdx) begin
      if (r_mem_valid && r_mem_wr_en && !r_mem_is_load && (r_mem_rd == rs))
        f_sel = SEL_MEM;
      else if (r_wb_valid && r_wb_wr_en && (r_wb_rd == rs))
        f_sel = SEL_WB;
    end
  endfunction

  always_comb begin
    w_sel_a = f_sel(r_ex_rs_a, r_ex_rd_a);
    w_sel_b = f_sel(r_ex_rs_b, r_ex_rd_b);
    case (w_sel_a)
      SEL_MEM: w_opa = mem_frwd_data;
      SEL_WB:  w_opa = wb_data;
      default: w_opa = r_ex_opa;
    endcase
    case (w_sel_b)
      SEL_MEM: w_opb = mem_frwd_data;
      SEL_WB:  w_opb = wb_data;
      default: w_opb = r_ex_opb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_wr_en    <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_ex_rs_a     <= '0;
      r_ex_rs_b     <= '0;
      r_ex_rd_a     <= 1'b0;
      r_ex_rd_b     <= 1'b0;
      r_ex_opa      <= '0;
      r_ex_opb      <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_rd      <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_is_load <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_rd       <= '0;
      r_wb_wr_en    <= 1'b0;
      r_wb_is_load  <= 1'b0;
      r_hazard_err  <= 1'b0;
      r_stall_cnt   <= '0;
    end else if (!hold) begin
      r_wb_valid    <= r_mem_valid;
      r_wb_rd       <= r_mem_rd;
      r_wb_wr_en    <= r_mem_wr_en;
      r_wb_is_load  <= r_mem_is_load;
      r_mem_valid   <= r_ex_valid;
      r_mem_rd      <= r_ex_rd;
      r_mem_wr_en   <= r_ex_wr_en;
      r_mem_is_load <= r_ex_is_load;
      r_ex_valid    <= id_valid & ~w_bubble;
      r_ex_wr_en    <= id_wr_en & ~w_bubble;
      r_ex_rd       <= id_rd;
      r_ex_is_load  <= id_is_load;
      r_ex_rs_a     <= id_rs_a;
      r_ex_rs_b     <= id_rs_b;
      r_ex_rd_a     <= id_rd_a;
      r_ex_rd_b     <= id_rd_b;
      r_ex_opa      <= w_cap_a;
      r_ex_opb      <= w_cap_b;
      if (w_haz)
        r_hazard_err <= 1'b1;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_id   = w_stall;
  assign ex_valid   = r_ex_valid;
  assign ex_rd      = r_ex_rd;
  assign ex_wr_en   = r_ex_wr_en;
  assign ex_is_load = r_ex_is_load;
  assign ex_opa     = w_opa;
  assign ex_opb     = w_opb;
  assign fwd_sel_a  = w_sel_a;
  assign fwd_sel_b  = w_sel_b;
  assign hazard_err = r_hazard_err;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_operand_forward_ctrl.sv
// Self-checking bench for operand_forward_ctrl: directed scenarios plus a
// randomized run against an instruction-level pipeline model.
module tb_operand_forward_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, hold, flush, id_valid;
  logic [AW-1:0]    id_rs_a, id_rs_b, id_rd;
  logic             id_rd_a, id_rd_b, id_wr_en, id_is_load;
  logic [DW-1:0]    id_opa, id_opb, mem_frwd_data, wb_data;
  logic             stall_id, ex_valid, ex_wr_en, ex_is_load, hazard_err;
  logic [AW-1:0]    ex_rd;
  logic [DW-1:0]    ex_opa, ex_opb;
  logic [1:0]       fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  operand_forward_ctrl #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
    .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .id_opa(id_opa), .id_opb(id_opb), .mem_frwd_data(mem_frwd_data), .wb_data(wb_data),
    .stall_id(stall_id), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .ex_opa(ex_opa), .ex_opb(ex_opb),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .hazard_err(hazard_err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction records occupying EX, MEM and WB in the model.
  typedef struct packed {
    logic        v;
    logic [2:0]  rd;
    logic        we;
    logic        ld;
    logic [2:0]  rsa;
    logic [2:0]  rsb;
    logic        ra;
    logic        rb;
    logic [15:0] oa;
    logic [15:0] ob;
  } ins_t;

  ins_t        m_ex, m_mem, m_wb;
  logic        m_haz;
  logic [15:0] m_cnt;
  bit          ignore_stall = 1'b0;

  function automatic void model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_haz = 1'b0; m_cnt = '0;
  endfunction

  function automatic logic m_stall();
    if (ignore_stall || !id_valid || flush) return 1'b0;
    if (!(m_ex.v && m_ex.we && m_ex.ld)) return 1'b0;
    return (id_rd_a && id_rs_a == m_ex.rd) || (id_rd_b && id_rs_b == m_ex.rd);
  endfunction

  // Youngest producer wins; a load in MEM has no data yet, so look further back.
  function automatic void exp_opnd(input logic [2:0] rs, input logic rdx, input logic [15:0] q,
                                   output logic [1:0] sel, output logic [15:0] val);
    ins_t prod [2];
    prod[0] = m_mem;
    prod[1] = m_wb;
    sel = 2'b00;
    val = q;
    if (!(m_ex.v && rdx)) return;
    for (int i = 0; i < 2; i++) begin
      if (prod[i].v && prod[i].we && prod[i].rd == rs) begin
        if (i == 0 && prod[i].ld) continue;
        sel = (i == 0) ? 2'b01 : 2'b10;
        val = (i == 0) ? mem_frwd_data : wb_data;
        return;
      end
    end
  endfunction

  function automatic void model_edge();
    ins_t nx;
    logic st;
    if (hold) return;
    st = m_stall();
    if (m_ex.v && m_mem.v && m_mem.we && m_mem.ld &&
        ((m_ex.ra && m_ex.rsa == m_mem.rd) || (m_ex.rb && m_ex.rsb == m_mem.rd)))
      m_haz = 1'b1;
    if (st && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    nx.v   = id_valid && !(flush || st);
    nx.we  = id_wr_en && !(flush || st);
    nx.rd  = id_rd;
    nx.ld  = id_is_load;
    nx.rsa = id_rs_a;
    nx.rsb = id_rs_b;
    nx.ra  = id_rd_a;
    nx.rb  = id_rd_b;
    nx.oa  = (m_wb.v && m_wb.we && id_rd_a && id_rs_a == m_wb.rd) ? wb_data : id_opa;
    nx.ob  = (m_wb.v && m_wb.we && id_rd_b && id_rs_b == m_wb.rd) ? wb_data : id_opb;
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = nx;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] rsa, input logic ra,
                        input logic [2:0] rsb, input logic rb, input logic [2:0] rd,
                        input logic we, input logic ld, input logic [15:0] oa, input logic [15:0] ob);
    id_valid = v; id_rs_a = rsa; id_rd_a = ra; id_rs_b = rsb; id_rd_b = rb;
    id_rd = rd; id_wr_en = we; id_is_load = ld; id_opa = oa; id_opb = ob;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_reset();
    idle();
    hold = 1'b0; flush = 1'b0; mem_frwd_data = 16'h5A5A; wb_data = 16'hA5A5;
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", stall_id); end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL rst_ex_valid got=%b exp=0", ex_valid); end
    checks++; if ({fwd_sel_a, fwd_sel_b} !== 4'b0000) begin failures++; $display("FAIL rst_sel got=%b%b exp=0000", fwd_sel_a, fwd_sel_b); end
    checks++; if (ex_opa !== 16'h0 || ex_opb !== 16'h0) begin failures++; $display("FAIL rst_ops got=%h/%h exp=0000/0000", ex_opa, ex_opb); end
    checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL rst_hazard got=%b exp=0", hazard_err); end
    checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_alu_mem_fwd();
    drain();
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 16'h1111, 16'h2222);
    step();
    set_id(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 3'd6, 1'b1, 1'b0, 16'h0BAD, 16'h0777);
    step();
    idle();
    mem_frwd_data = 16'h00A5;
    #1;
    checks++; if (fwd_sel_a !== 2'b01) begin failures++; $display("FAIL mem_fwd_sel_a got=%b exp=01", fwd_sel_a); end
    checks++; if (ex_opa !== 16'h00A5) begin failures++; $display("FAIL mem_fwd_opa got=%h exp=00a5", ex_opa); end
    checks++; if (fwd_sel_b !== 2'b00 || ex_opb !== 16'h0777) begin failures++; $display("FAIL mem_fwd_opb got=%b/%h exp=00/0777", fwd_sel_b, ex_opb); end
  endtask

  task automatic test_wb_fwd();
    drain();
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    set_id(1'b1, 3'd7, 1'b1, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    set_id(1'b1, 3'd5, 1'b1, 3'd2, 1'b1, 3'd7, 1'b1, 1'b0, 16'h0BEE, 16'hDEAD);
    step();
    idle();
    wb_data = 16'h1234;
    mem_frwd_data = 16'h9999;
    #1;
    checks++; if (fwd_sel_b !== 2'b10) begin failures++; $display("FAIL wb_fwd_sel_b got=%b exp=10", fwd_sel_b); end
    checks++; if (ex_opb !== 16'h1234) begin failures++; $display("FAIL wb_fwd_opb got=%h exp=1234", ex_opb); end
    checks++; if (fwd_sel_a !== 2'b00 || ex_opa !== 16'h0BEE) begin failures++; $display("FAIL wb_fwd_opa got=%b/%h exp=00/0bee", fwd_sel_a, ex_opa); end
  endtask

  task automatic test_load_use();
    drain();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0001, 16'h0);
    step();
    set_id(1'b1, 3'd4, 1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 1'b0, 16'h0444, 16'h0111);
    #1;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_id); end
    step();
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL lu_stall_drop got=%b exp=0", stall_id); end
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble got=%b exp=0", ex_valid); end
    step();
    idle();
    wb_data = 16'hBEEF;
    #1;
    checks++; if (ex_valid !== 1'b1 || fwd_sel_a !== 2'b10) begin failures++; $display("FAIL lu_sel_a got=%b/%b exp=1/10", ex_valid, fwd_sel_a); end
    checks++; if (ex_opa !== 16'hBEEF) begin failures++; $display("FAIL lu_opa got=%h exp=beef", ex_opa); end
    checks++; if (ex_opb !== 16'h0111) begin failures++; $display("FAIL lu_opb got=%h exp=0111", ex_opb); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (hazard_err !== 1'b0) begin failures++; $display("FAIL lu_hazard got=%b exp=0", hazard_err); end
  endtask

  task automatic test_flush_priority();
    logic [15:0] c0;
    drain();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0, 16'h0);
    step();
    set_id(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0, 16'h0, 16'h0);
    flush = 1'b1;
    #1;
    c0 = stall_cnt;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_id); end
    step();
    flush = 1'b0;
    idle();
    #1;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", ex_valid); end
    checks++; if (stall_cnt !== c0) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, c0); end
  endtask

  task automatic test_hold();
    logic [15:0] c0, oa0, ob0;
    logic [2:0]  rd0;
    drain();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 16'h00C1, 16'h0);
    step();
    set_id(1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 3'd6, 1'b1, 1'b0, 16'h0, 16'h0066);
    #1;
    c0 = stall_cnt; oa0 = ex_opa; ob0 = ex_opb; rd0 = ex_rd;
    checks++; if (stall_id !== 1'b1) begin failures++; $display("FAIL hold_stall_pre got=%b exp=1", stall_id); end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (stall_id !== 1'b1 || ex_valid !== 1'b1 || ex_rd !== 3'd4 || ex_is_load !== 1'b1 ||
          ex_rd !== rd0 || ex_opa !== oa0 || ex_opb !== ob0 || stall_cnt !== c0) begin
        failures++;
        $display("FAIL hold_freeze cyc=%0d got stall=%b v=%b rd=%0d ld=%b cnt=%0d exp stall=1 v=1 rd=4 ld=1 cnt=%0d",
                 i, stall_id, ex_valid, ex_rd, ex_is_load, stall_cnt, c0);
      end
    end
    hold = 1'b0;
    step();
    checks++; if (ex_valid !== 1'b0 || stall_id !== 1'b0) begin failures++; $display("FAIL hold_bubble got v=%b stall=%b exp v=0 stall=0", ex_valid, stall_id); end
    checks++; if (stall_cnt !== c0 + 16'd1) begin failures++; $display("FAIL hold_cnt got=%0d exp=%0d", stall_cnt, c0 + 16'd1); end
    step();
    idle();
    wb_data = 16'h4321;
    #1;
    checks++; if (ex_valid !== 1'b1 || fwd_sel_b !== 2'b10 || ex_opb !== 16'h4321) begin failures++; $display("FAIL hold_resume got v=%b sel=%b opb=%h exp v=1 sel=10 opb=4321", ex_valid, fwd_sel_b, ex_opb); end
  endtask

  task automatic test_back_to_back();
    logic        es;
    logic [1:0]  sa, sb;
    logic [15:0] va, vb;
    drain();
    for (int n = 0; n < 400; n++) begin
      hold = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_rs_a = 3'($urandom_range(0, 3));
      id_rs_b = 3'($urandom_range(0, 3));
      id_rd_a = 1'($urandom_range(0, 1));
      id_rd_b = 1'($urandom_range(0, 1));
      id_rd = 3'($urandom_range(0, 3));
      id_wr_en = id_valid & 1'($urandom_range(0, 1));
      id_is_load = id_wr_en & ($urandom_range(0, 2) == 0);
      id_opa = 16'($urandom);
      id_opb = 16'($urandom);
      mem_frwd_data = 16'($urandom);
      wb_data = 16'($urandom);
      #1;
      es = m_stall();
      exp_opnd(m_ex.rsa, m_ex.ra, m_ex.oa, sa, va);
      exp_opnd(m_ex.rsb, m_ex.rb, m_ex.ob, sb, vb);
      checks++; if (stall_id !== es) begin failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_id, es); end
      checks++; if (ex_valid !== m_ex.v || ex_wr_en !== m_ex.we) begin failures++; $display("FAIL rnd_ex_flags n=%0d got=%b%b exp=%b%b", n, ex_valid, ex_wr_en, m_ex.v, m_ex.we); end
      if (m_ex.v) begin
        checks++; if (ex_rd !== m_ex.rd || ex_is_load !== m_ex.ld) begin failures++; $display("FAIL rnd_ex_rd n=%0d got=%0d/%b exp=%0d/%b", n, ex_rd, ex_is_load, m_ex.rd, m_ex.ld); end
      end
      checks++; if (fwd_sel_a !== sa || fwd_sel_b !== sb) begin failures++; $display("FAIL rnd_sel n=%0d got=%b/%b exp=%b/%b", n, fwd_sel_a, fwd_sel_b, sa, sb); end
      if (m_ex.v && m_ex.ra) begin
        checks++; if (ex_opa !== va) begin failures++; $display("FAIL rnd_opa n=%0d got=%h exp=%h", n, ex_opa, va); end
      end
      if (m_ex.v && m_ex.rb) begin
        checks++; if (ex_opb !== vb) begin failures++; $display("FAIL rnd_opb n=%0d got=%h exp=%h", n, ex_opb, vb); end
      end
      checks++; if (hazard_err !== m_haz || stall_cnt !== m_cnt) begin failures++; $display("FAIL rnd_haz_cnt n=%0d got=%b/%0d exp=%b/%0d", n, hazard_err, stall_cnt, m_haz, m_cnt); end
      step();
    end
    hold = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_hazard_err();
    drain();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1, 16'h0, 16'h0);
    step();
    force dut.w_stall = 1'b0;
    ignore_stall = 1'b1;
    set_id(1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 16'h0, 16'h0);
    #1;
    checks++; if (stall_id !== 1'b0) begin failures++; $display("FAIL haz_forced_stall got=%b exp=0", stall_id); end
    step();
    idle();
    release dut.w_stall;
    ignore_stall = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b1 || hazard_err !== 1'b0) begin failures++; $display("FAIL haz_pre got v=%b err=%b exp v=1 err=0", ex_valid, hazard_err); end
    step();
    checks++; if (hazard_err !== 1'b1) begin failures++; $display("FAIL haz_set got=%b exp=1", hazard_err); end
    drain();
    checks++; if (hazard_err !== 1'b1) begin failures++; $display("FAIL haz_sticky got=%b exp=1", hazard_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    hold = 1'b0;
    flush = 1'b0;
    test_reset();
    test_alu_mem_fwd();
    test_wb_fwd();
    test_load_use();
    test_flush_priority();
    test_hold();
    test_back_to_back();
    test_hazard_err();
    test_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_forward_ctrl.md
Name: operand_forward_ctrl

Overview:
- Consumer side of the MEM/WB result-forwarding path.
- Owns the ID/EX operand register and tracks destination-register info for the EX, MEM and WB stages.
- Selects each EX operand from one of three sources: the captured register-file value, the MEM-stage forward value (mem_frwd_data), or the WB write-back value.
- Generates the one-cycle load-use stall, which is what guarantees a load result is never requested from the MEM forward path.

Parameters:
DW, 16, datapath/operand width
AW, 3, register address width (8 GPRs)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
hold  input  1  global pipeline freeze; all internal state holds
flush  input  1  squash instruction in ID (branch redirect)
id_valid  input  1  ID holds a real instruction
id_rs_a / id_rs_b  input  AW  source register addresses
id_rd_a / id_rd_b  input  1  source A/B actually read
id_rd  input  AW  destination register
id_wr_en  input  1  instruction writes id_rd
id_is_load  input  1  instruction is a load
id_opa / id_opb  input  DW  register-file read values
mem_frwd_data  input  DW  forward value from MEM stage
wb_data  input  DW  write-back value
stall_id  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  EX holds a real instruction
ex_rd  output  AW  EX destination
ex_wr_en / ex_is_load  output  1  EX destination flags
ex_opa / ex_opb  output  DW  forwarded EX operands
fwd_sel_a / fwd_sel_b  output  2  00 regfile, 01 MEM, 10 WB
hazard_err  output  1  sticky protocol-violation flag
stall_cnt  output  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (rst_n=0, async): all stage valid bits 0, all rd/flag/operand registers 0, hazard_err 0, stall_cnt 0.
  - Consequence: stall_id=0, fwd_sel_*=00, ex_opa/ex_opb=0.
- Stage registers:
  - EX stage (also drives the ex_* outputs): valid, rd, wr_en, is_load, rs_a, rs_b, rd_a, rd_b, opa_q, opb_q.
  - MEM and WB stages: valid, rd, wr_en, is_load.
- Advance, on each posedge with hold=0:
  - WB takes MEM.
  - MEM takes EX.
  - EX takes ID, or a bubble if flush=1 or stall_id=1. A bubble is valid=0 and wr_en=0.
- hold=1 freezes everything, including stall_cnt; combinational outputs still track inputs.
- Load-use stall (combinational):
  - stall_id = id_valid & ~flush & EX.valid & EX.wr_en & EX.is_load & ((id_rd_a & id_rs_a==EX.rd) | (id_rd_b & id_rs_b==EX.rd)).
  - Exactly one bubble is inserted. On the next cycle the load is in MEM, no longer matches, and the stall drops.
  - The consumer enters EX when the load reaches WB and takes wb_data.
- flush has priority over stall: stall_id=0 and EX receives a bubble.
- ID-capture bypass: when loading EX from ID, if WB.valid & WB.wr_en & rs==WB.rd & rd_x, capture wb_data instead of id_opa/id_opb.
  - Covers the same-cycle regfile write/read, where the regfile returns the old value.
- EX operand select, per operand x, when EX.valid & EX.rd_x:
  - If MEM.valid & MEM.wr_en & MEM.rd==EX.rs_x & ~MEM.is_load: sel=01, operand=mem_frwd_data.
  - Else if WB.valid & WB.wr_en & WB.rd==EX.rs_x: sel=10, operand=wb_data.
  - Else: sel=00, operand=opx_q.
  - MEM has priority over WB because it is the younger producer.
- hazard_err:
  - Set when EX.valid & EX.rd_x & MEM.valid & MEM.wr_en & MEM.is_load & MEM.rd==EX.rs_x.
  - Stays set until reset. It is unreachable when stall_id is honoured.
- stall_cnt increments on each non-hold cycle with stall_id=1 and saturates at all-ones.

Test Plan:
- Reset, then ADD r3 (ALU) followed by a reader of r3 with mem_frwd_data=16'h00A5 → fwd_sel_a=01 and ex_opa=16'h00A5 in the reader's EX cycle.
- Producer of r2 with one unrelated instruction between it and the reader, wb_data=16'h1234 → fwd_sel_b=10, ex_opb=16'h1234.
- LW r4, then ADD r5,r4,r1 → stall_id=1 for exactly one cycle, ex_valid=0 for one cycle, then fwd_sel_a=10 with ex_opa=wb_data, stall_cnt=1, hazard_err=0.
- Load-use condition with flush=1 in the same cycle → stall_id=0, ex_valid=0 next cycle, stall_cnt unchanged.
- Drive the consumer into EX while ignoring stall_id (load in MEM) → hazard_err=1 and stays 1 until rst_n asserted.
- Load-use stall with hold=1 for 3 cycles → all ex_* outputs and stall_cnt frozen, stall_id stays 1. Release hold → one bubble, then normal flow.
